lcd_frame_sequencer: RTL and testbench

//  Successor to the fixed-message LCD display sequencer. Holds a writable NUM_LINES x LINE_LEN

---
 rtl/lcd_frame_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// Streams a writable NUM_LINES x LINE_LEN character frame buffer to an LCD controller over START/DONE.
// Define LCD_INIT_SEQ_EN to issue the 0x38/0x0C/0x06/0x01 power-on init sequence after reset.
module lcd_frame_sequencer #(
  parameter int unsigned NUM_LINES   = 2,
  parameter int unsigned LINE_LEN    = 16,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              CLK1K,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [7:0]        WR_DATA,
  input  logic              UPDATE_REQ,
  input  logic              CMD_DONE,
  output logic [7:0]        CMD_DATA,
  output logic              CMD_RS,
  output logic              CMD_START,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              TIMEOUT_ERR
);

  localparam int unsigned NUM_CHARS = NUM_LINES * LINE_LEN;
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned LINE_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int unsigned COL_W     = $clog2(LINE_LEN + 1);
  localparam int unsigned CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

`ifdef LCD_INIT_SEQ_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [7:0]         buf_q [DEPTH];
  logic [7:0]         buf_d [DEPTH];
  logic               hdr_q, hdr_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic               init_q, init_d;
  logic [1:0]         init_idx_q, init_idx_d;
  logic [7:0]         cmd_data_q, cmd_data_d;
  logic               cmd_rs_q, cmd_rs_d;
  logic               cmd_start_q, cmd_start_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               timeout_err_q, timeout_err_d;

  logic [7:0]         item_data_c;
  logic               item_rs_c;
  logic               item_last_c;
  logic               timeout_hit_c;

  function automatic logic [7:0] line_base(input logic [LINE_W-1:0] l);
    case (2'(l))
      2'd0:    line_base = 8'h00;
      2'd1:    line_base = 8'h40;
      2'd2:    line_base = 8'h14;
      default: line_base = 8'h54;
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // Current item decode: clear, per-line address command (col 0), or buffer character.
  always_comb begin
    item_last_c = !hdr_q && (line_q == LINE_W'(NUM_LINES - 1)) && (col_q == COL_W'(LINE_LEN));
    item_rs_c   = 1'b0;
    if (hdr_q) begin
      item_data_c = 8'h01;
    end else if (col_q == '0) begin
      item_data_c = 8'h80 | line_base(line_q);
    end else begin
      item_data_c = buf_q[ptr_q];
      item_rs_c   = 1'b1;
    end
    if (init_q) begin
      item_data_c = init_cmd(init_idx_q);
      item_rs_c   = 1'b0;
      item_last_c = (init_idx_q == 2'd3);
    end
  end

  assign timeout_hit_c = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    hdr_d         = hdr_q;
    line_d        = line_q;
    col_d         = col_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    init_d        = init_q;
    init_idx_d    = init_idx_q;
    cmd_data_d    = cmd_data_q;
    cmd_rs_d      = cmd_rs_q;
    cmd_start_d   = 1'b0;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;

    if (WR_EN && (32'(WR_ADDR) < NUM_CHARS)) begin
      buf_d[WR_ADDR] = WR_DATA;
    end

    case (state_q)
      S_IDLE: begin
        if (UPDATE_REQ || pending_q) begin
          pending_d     = 1'b0;
          timeout_err_d = 1'b0;
          hdr_d         = 1'b1;
          line_d        = '0;
          col_d         = '0;
          ptr_d         = '0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pending_d   = pending_q | WR_EN | UPDATE_REQ;
        cmd_data_d  = item_data_c;
        cmd_rs_d    = item_rs_c;
        cmd_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        pending_d = pending_q | WR_EN | UPDATE_REQ;
        if (CMD_DONE) begin
          if (item_last_c) begin
            frame_done_d = !init_q;
            init_d       = 1'b0;
            state_d      = S_IDLE;
          end else begin
            state_d = S_ISSUE;
            if (init_q) begin
              init_idx_d = init_idx_q + 2'd1;
            end else if (hdr_q) begin
              hdr_d = 1'b0;
            end else begin
              if (col_q != '0) begin
                ptr_d = ptr_q + ADDR_W'(1);
              end
              if (col_q == COL_W'(LINE_LEN)) begin
                line_d = line_q + LINE_W'(1);
                col_d  = '0;
              end else begin
                col_d = col_q + COL_W'(1);
              end
            end
          end
        end else if (timeout_hit_c) begin
          // Abandon the frame; queued refresh requests are dropped with it.
          timeout_err_d = 1'b1;
          pending_d     = 1'b0;
          init_d        = 1'b0;
          state_d       = S_IDLE;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || pending_d;
  end

  always_ff @(posedge CLK1K) begin
    if (RST) begin
      if (INIT_EN) state_q <= S_ISSUE;
      else         state_q <= S_IDLE;
      buf_q         <= '{default: 8'h20};
      hdr_q         <= 1'b0;
      line_q        <= '0;
      col_q         <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      init_q        <= INIT_EN;
      init_idx_q    <= 2'd0;
      cmd_data_q    <= 8'h00;
      cmd_rs_q      <= 1'b0;
      cmd_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      hdr_q         <= hdr_d;
      line_q        <= line_d;
      col_q         <= col_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      init_q        <= init_d;
      init_idx_q    <= init_idx_d;
      cmd_data_q    <= cmd_data_d;
      cmd_rs_q      <= cmd_rs_d;
      cmd_start_q   <= cmd_start_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign CMD_DATA    = cmd_data_q;
  assign CMD_RS      = cmd_rs_q;
  assign CMD_START   = cmd_start_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = frame_done_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer: directed scenarios plus randomized frames against a buffer/item-list model.
module tb_lcd_frame_sequencer;

  localparam int LINES = 2;
  localparam int LEN   = 16;
  localparam int NCH   = LINES * LEN;
  localparam int TOTAL = 1 + LINES * (LEN + 1);
  localparam int TMO   = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       upd = 1'b0;
  logic       cmd_done = 1'b0;
  logic [7:0] cmd_data;
  logic       cmd_rs, cmd_start, busy, frame_done, timeout_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mbuf  [64];
  logic [7:0] mprev [64];
  logic [7:0] base_tab [4] = '{8'h00, 8'h40, 8'h14, 8'h54};
  logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  lcd_frame_sequencer #(
    .NUM_LINES(LINES), .LINE_LEN(LEN), .TIMEOUT_CYC(TMO), .ADDR_W(6)
  ) dut (
    .CLK1K(clk), .RST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .UPDATE_REQ(upd), .CMD_DONE(cmd_done), .CMD_DATA(cmd_data), .CMD_RS(cmd_rs),
    .CMD_START(cmd_start), .BUSY(busy), .FRAME_DONE(frame_done), .TIMEOUT_ERR(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the model buffer follows the same edge, mprev keeps the pre-edge view.
  task automatic tick();
    mprev = mbuf;
    if (rst) mbuf = '{default: 8'h20};
    else if (wr_en && int'(wr_addr) < NCH) mbuf[wr_addr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  // Expected {rs, byte} of item i, derived from the frame layout and the buffer seen at issue time.
  function automatic logic [8:0] exp_item(input int i);
    int k, l, p;
    if (i == 0) return {1'b0, 8'h01};
    k = i - 1;
    l = k / (LEN + 1);
    p = k % (LEN + 1);
    if (p == 0) return {1'b0, 8'h80 | base_tab[2'(l)]};
    return {1'b1, mprev[6'(l * LEN + p - 1)]};
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Acts as the controller for one frame; returns early after START number stall_at if nonzero.
  task automatic serve_frame(input int lat, input int ev_pct, input int ev_left_in,
                             input int stall_at, output bit ev_seen);
    int n, cd, last_done, ev_left;
    bit fin;
    logic [8:0] e;
    n = 0; cd = -1; fin = 1'b0; ev_seen = 1'b0; last_done = 0; ev_left = ev_left_in;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      tick();
      cmd_done = 1'b0; wr_en = 1'b0; upd = 1'b0;
      if (cmd_start) begin
        if (n < TOTAL) begin
          e = exp_item(n);
          chk("item_data", 32'(cmd_data), 32'(e[7:0]));
          chk("item_rs", 32'(cmd_rs), 32'(e[8]));
        end else begin
          chk("extra_start", 32'(cmd_start), 32'(0));
        end
        chk("busy_item", 32'(busy), 32'(1));
        n++;
        if (n == stall_at) fin = 1'b1;
        else cd = lat;
      end
      if (frame_done) begin
        chk("frame_len", n, TOTAL);
        chk("fd_latency", cyc - last_done, 1);
        chk("busy_after_frame", 32'(busy), 32'(ev_seen));
        fin = 1'b1;
      end
      if (cd == 0) begin
        cmd_done = 1'b1; cd = -1; last_done = cyc;
      end else if (cd > 0) begin
        cd--;
      end
      if (!fin && ev_left > 0 && n >= 1 && n <= TOTAL - 5 && $urandom_range(99) < ev_pct) begin
        ev_seen = 1'b1;
        if (ev_left > 2) begin
          wr_en = 1'b1;
          wr_addr = 6'($urandom_range(NCH + 7));
          wr_data = 8'($urandom_range(33, 126));
        end else begin
          upd = 1'b1;
        end
        ev_left--;
      end
    end
    chk("frame_end_in_budget", 32'(fin), 32'(1));
  endtask

  task automatic expect_quiet(input string tag, input bit pulse);
    int starts;
    starts = 0;
    cmd_done = pulse;
    for (int c = 0; c < 8; c++) begin
      tick();
      cmd_done = 1'b0;
      if (cmd_start) starts++;
    end
    chk(tag, starts, 0);
    chk("quiet_busy", 32'(busy), 32'(0));
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic serve_init(input bit req);
    int n, cd;
    bit last;
    n = 0; cd = -1; last = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      tick();
      cmd_done = 1'b0; upd = 1'b0;
      if (last) break;
      if (cmd_start) begin
        chk("init_data", 32'(cmd_data), 32'(init_tab[2'(n)]));
        chk("init_rs", 32'(cmd_rs), 32'(0));
        chk("init_busy", 32'(busy), 32'(1));
        n++;
        cd = 1;
        if (n == 1 && req) upd = 1'b1;
      end
      chk("init_no_fd", 32'(frame_done), 32'(0));
      if (cd == 0) begin
        cmd_done = 1'b1; cd = -1;
        if (n == 4) last = 1'b1;
      end else if (cd > 0) begin
        cd--;
      end
    end
    chk("init_count", n, 4);
    chk("init_end_busy", 32'(busy), 32'(req));
  endtask
`endif

  initial begin
    bit ev, ev2;
    int lat, fd_seen, st_seen;
    mbuf  = '{default: 8'h20};
    mprev = '{default: 8'h20};

    // Reset values while RST is held.
    rst = 1'b1;
    tick(); tick();
    chk("rst_data", 32'(cmd_data), 32'(0));
    chk("rst_rs", 32'(cmd_rs), 32'(0));
    chk("rst_start", 32'(cmd_start), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_fd", 32'(frame_done), 32'(0));
    chk("rst_tmo", 32'(timeout_err), 32'(0));
    rst = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    serve_init(1'b1);
    serve_frame(1, 0, 0, 0, ev);
`endif

    // Blank frame with DONE one cycle after each START.
    upd = 1'b1;
    serve_frame(1, 0, 0, 0, ev);
    expect_quiet("idle_after_frame", 1'b0);

    // Corner addresses; address 32 is outside the buffer.
    do_write(6'd0, 8'h41);
    do_write(6'd31, 8'h5A);
    do_write(6'd32, 8'h55);
    upd = 1'b1;
    serve_frame(0, 0, 0, 0, ev);

    // Writes and requests during a frame coalesce into exactly one extra frame.
    upd = 1'b1;
    serve_frame(1, 30, 5, 0, ev);
    chk("coalesce_pending", 32'(ev), 32'(1));
    serve_frame(2, 0, 0, 0, ev2);
    expect_quiet("single_extra_frame", 1'b0);

    // Request and write in the same idle cycle.
    upd = 1'b1; wr_en = 1'b1; wr_addr = 6'd17; wr_data = 8'h4D;
    serve_frame(1, 0, 0, 0, ev);

    // Stall after the 5th START until the wait budget expires.
    upd = 1'b1;
    serve_frame(1, 0, 0, 5, ev);
    fd_seen = 0; st_seen = 0;
    for (int c = 0; c < TMO - 1; c++) begin
      tick();
      if (frame_done) fd_seen++;
      if (cmd_start) st_seen++;
    end
    chk("tmo_not_early", 32'(timeout_err), 32'(0));
    tick();
    if (frame_done) fd_seen++;
    chk("tmo_set", 32'(timeout_err), 32'(1));
    chk("tmo_busy", 32'(busy), 32'(0));
    chk("tmo_no_fd", fd_seen, 0);
    chk("tmo_no_start", st_seen, 0);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    chk("tmo_cleared", 32'(timeout_err), 32'(0));
    serve_frame(1, 0, 0, 0, ev);

    // Reset mid-frame, then a late DONE.
    do_write(6'd5, 8'h37);
    upd = 1'b1;
    serve_frame(1, 0, 0, 10, ev);
    rst = 1'b1;
    tick();
    chk("midrst_start", 32'(cmd_start), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    serve_init(1'b0);
`else
    expect_quiet("late_done_no_start", 1'b1);
`endif
    upd = 1'b1;
    serve_frame(1, 0, 0, 0, ev);

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 4)) do_write(6'($urandom_range(NCH + 7)), 8'($urandom_range(33, 126)));
      lat = int'($urandom_range(0, 3));
      upd = 1'b1;
      serve_frame(lat, 15, int'($urandom_range(0, 4)), 0, ev);
      if (ev) serve_frame(lat, 0, 0, 0, ev2);
      expect_quiet("rand_idle", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
